// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC blocks: micro-rotation angle table (integer
// degrees), controller state encoding and the internal guard-bit count.
package cordic_pkg;

    localparam int GUARD_BITS   = 2;
    localparam int ATAN_ENTRIES = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        COMP = 2'd2,
        FIN  = 2'd3
    } state_e;

    // atan(2^-k) rounded to whole degrees; same table as the vectoring block
    function automatic logic [5:0] atan_deg(input logic [2:0] k);
        case (k)
            3'd0:    atan_deg = 6'd45;
            3'd1:    atan_deg = 6'd26;
            3'd2:    atan_deg = 6'd14;
            3'd3:    atan_deg = 6'd7;
            3'd4:    atan_deg = 6'd4;
            3'd5:    atan_deg = 6'd2;
            3'd6:    atan_deg = 6'd1;
            default: atan_deg = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_rot_if.sv
// Handshake and data bundle of the polar-to-rectangular CORDIC.
// master drives the request side, slave is the converter.
interface cordic_rot_if #(
    parameter int W = 7
);
    logic              start;
    logic signed [W:0] r_in;
    logic signed [W:0] phi_in;
    logic              busy;
    logic              done;
    logic signed [W:0] x_out;
    logic signed [W:0] y_out;

    modport master (
        output start, r_in, phi_in,
        input  busy, done, x_out, y_out
    );

    modport slave (
        input  start, r_in, phi_in,
        output busy, done, x_out, y_out
    );
endinterface

// File: rtl/cordic_sat.sv
// Signed saturating narrowing from IN_W to OUT_W bits; values outside the
// output range clamp to its most positive / most negative code.
module cordic_sat
    import cordic_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int IN_W  = OUT_W + GUARD_BITS
) (
    input  logic signed [IN_W-1:0]  d_in,
    output logic signed [OUT_W-1:0] d_out
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    // Clamp against the output range limits
    always_comb begin
        if (d_in > MAX_V) begin
            d_out = MAX_V[OUT_W-1:0];
        end else if (d_in < MIN_V) begin
            d_out = MIN_V[OUT_W-1:0];
        end else begin
            d_out = d_in[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/cordic_rot.sv
// Iterative rotation-mode CORDIC: (radius, phase in degrees) -> saturated (x, y).
// Optional gain compensation stage enabled by CORDIC_ROT_GAIN_COMP_EN.
module cordic_rot
    import cordic_pkg::*;
#(
    parameter int W    = 7,
    parameter int ITER = 3
) (
    input  logic         clk,
    input  logic         reset,
    cordic_rot_if.slave  bus
);

    localparam int DW = W + 1 + GUARD_BITS;
    typedef logic signed [DW-1:0] dat_t;

    localparam dat_t PHI_90 = dat_t'(32'sd90);

    state_e            state_q, state_d;
    dat_t              x_q, x_d, y_q, y_d, z_q, z_d;
    logic [2:0]        k_q, k_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic signed [W:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic signed [W:0] x_sat_s, y_sat_s;
    dat_t              r_ext_s, phi_ext_s, x_sh_s, y_sh_s, atan_s;
    logic              last_iter_s;

`ifdef CORDIC_ROT_GAIN_COMP_EN
    // Approximates 1/1.647 = 0.5 + 0.125 - 0.0156
    function automatic dat_t gain_comp(input dat_t v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6);
    endfunction
`endif

    assign r_ext_s     = DW'(bus.r_in);
    assign phi_ext_s   = DW'(bus.phi_in);
    assign x_sh_s      = x_q >>> k_q;
    assign y_sh_s      = y_q >>> k_q;
    assign atan_s      = DW'({1'b0, atan_deg(k_q)});
    assign last_iter_s = (k_q == 3'(ITER - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ROT;
                end else begin
                    state_d = IDLE;
                end
            end
            ROT: begin
                if (last_iter_s) begin
`ifdef CORDIC_ROT_GAIN_COMP_EN
                    state_d = COMP;
`else
                    state_d = FIN;
`endif
                end else begin
                    state_d = ROT;
                end
            end
            COMP:    state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output / datapath next values
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        k_d     = k_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        done_d  = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_d = 3'd0;
                    // Fold |phi| >= 90 into the converging range with an exact 90-degree turn
                    if (phi_ext_s >= PHI_90) begin
                        x_d = '0;
                        y_d = r_ext_s;
                        z_d = phi_ext_s - PHI_90;
                    end else if (phi_ext_s <= -PHI_90) begin
                        x_d = '0;
                        y_d = -r_ext_s;
                        z_d = phi_ext_s + PHI_90;
                    end else begin
                        x_d = r_ext_s;
                        y_d = '0;
                        z_d = phi_ext_s;
                    end
                end else begin
                    k_d = k_q;
                end
            end
            ROT: begin
                k_d = k_q + 3'd1;
                if (!z_q[DW-1]) begin
                    x_d = x_q - y_sh_s;
                    y_d = y_q + x_sh_s;
                    z_d = z_q - atan_s;
                end else begin
                    x_d = x_q + y_sh_s;
                    y_d = y_q - x_sh_s;
                    z_d = z_q + atan_s;
                end
            end
`ifdef CORDIC_ROT_GAIN_COMP_EN
            COMP: begin
                x_d = gain_comp(x_q);
                y_d = gain_comp(y_q);
            end
`endif
            FIN: begin
                done_d  = 1'b1;
                x_out_d = x_sat_s;
                y_out_d = y_sat_s;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            k_q     <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
        end
    end

    cordic_sat #(.OUT_W(W + 1), .IN_W(DW)) u_sat_x (.d_in(x_q), .d_out(x_sat_s));
    cordic_sat #(.OUT_W(W + 1), .IN_W(DW)) u_sat_y (.d_in(y_q), .d_out(y_sat_s));

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.x_out = x_out_q;
    assign bus.y_out = y_out_q;

endmodule

// File: tb/tb_cordic_rot.sv
// Bench for cordic_rot: cycle reference model of the handshake plus an
// integer model of the conversion, compared against the DUT every cycle.
module tb_cordic_rot;

    localparam int W    = 7;
    localparam int ITER = 3;
`ifdef CORDIC_ROT_GAIN_COMP_EN
    localparam int LAT  = ITER + 2;
`else
    localparam int LAT  = ITER + 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cordic_rot_if #(.W(W)) bus ();
    cordic_rot #(.W(W), .ITER(ITER)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int m_cnt = 0, m_busy = 0, m_done = 0, m_x = 0, m_y = 0, m_px = 0, m_py = 0;
    bit chk_en = 1'b0;
    int atan_tab [7] = '{45, 26, 14, 7, 4, 2, 1};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_conv(input int r, input int phi, output int xo, output int yo);
        int x, y, z, t;
        if (phi >= 90) begin
            x = 0; y = r; z = phi - 90;
        end else if (phi <= -90) begin
            x = 0; y = -r; z = phi + 90;
        end else begin
            x = r; y = 0; z = phi;
        end
        for (int k = 0; k < ITER; k++) begin
            if (z >= 0) begin
                t = x - (y >>> k); y = y + (x >>> k); x = t; z = z - atan_tab[k];
            end else begin
                t = x + (y >>> k); y = y - (x >>> k); x = t; z = z + atan_tab[k];
            end
        end
`ifdef CORDIC_ROT_GAIN_COMP_EN
        x = (x >>> 1) + (x >>> 3) - (x >>> 6);
        y = (y >>> 1) + (y >>> 3) - (y >>> 6);
`endif
        xo = (x > 2**W - 1) ? 2**W - 1 : (x < -(2**W)) ? -(2**W) : x;
        yo = (y > 2**W - 1) ? 2**W - 1 : (y < -(2**W)) ? -(2**W) : y;
    endfunction

    // Reference handshake: idle countdown; accept loads LAT cycles of work
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_cnt = 0; m_busy = 0; m_done = 0; m_x = 0; m_y = 0;
            end else begin
                m_done = 0;
                if (m_cnt == 0) begin
                    if (bus.start) begin
                        ref_conv(int'(bus.r_in), int'(bus.phi_in), m_px, m_py);
                        m_cnt  = LAT;
                        m_busy = 1;
                    end
                end else begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy = 0; m_done = 1; m_x = m_px; m_y = m_py;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the reference
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy",  int'(bus.busy),  m_busy);
                check("done",  int'(bus.done),  m_done);
                check("x_out", int'(bus.x_out), m_x);
                check("y_out", int'(bus.y_out), m_y);
            end
        end
    end

    task automatic run_one(input int r, input int phi, input int ex, input int ey);
        bit seen = 1'b0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.r_in   = (W+1)'(r);
        bus.phi_in = (W+1)'(phi);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", int'(seen), 1);
        check("lit_x", int'(bus.x_out), ex);
        check("lit_y", int'(bus.y_out), ey);
    endtask

    int tab_r   [4] = '{60, 60, 60, 100};
    int tab_phi [4] = '{0, 90, -90, 0};
`ifdef CORDIC_ROT_GAIN_COMP_EN
    int tab_x   [4] = '{59, -4, 3, 99};
    int tab_y   [4] = '{5, 60, -60, 7};
`else
    int tab_x   [4] = '{97, -8, 7, 127};
    int tab_y   [4] = '{8, 98, -97, 13};
`endif

    initial begin
        int mx, my;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.r_in   = '0;
        bus.phi_in = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_x", int'(bus.x_out), 0);
        reset = 1'b0;

        // Pin the model itself to hand-computed values
        for (int i = 0; i < 4; i++) begin
            ref_conv(tab_r[i], tab_phi[i], mx, my);
            check("model_x", mx, tab_x[i]);
            check("model_y", my, tab_y[i]);
        end

        for (int i = 0; i < 4; i++) begin
            run_one(tab_r[i], tab_phi[i], tab_x[i], tab_y[i]);
        end

        // start held high: back-to-back conversions, inputs changing meanwhile
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            bus.start  = 1'b1;
            bus.r_in   = (W+1)'($urandom_range(0, 255));
            bus.phi_in = (W+1)'(int'($urandom_range(0, 254)) - 127);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // start pulsed mid-conversion must be ignored
        bus.start = 1'b1; bus.r_in = 8'sd60; bus.phi_in = 8'sd0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.r_in = 8'sd100; bus.phi_in = 8'sd45;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // reset during iteration 2 aborts the conversion
        bus.start = 1'b1; bus.r_in = 8'sd60; bus.phi_in = 8'sd30;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_x", int'(bus.x_out), 0);
        check("abort_y", int'(bus.y_out), 0);
        run_one(tab_r[0], tab_phi[0], tab_x[0], tab_y[0]);

        // Randomized traffic with sparse resets, including reset with start
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.r_in   = (W+1)'($urandom_range(0, 255));
            bus.phi_in = (W+1)'(int'($urandom_range(0, 254)) - 127);
            reset      = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (LAT + 3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
